// File: rtl/rgb2hsv_pkg.sv
// Shared constants, divider sizing and FSM state encoding for the RGB-to-HSV converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rgb2hsv_pkg;

   // Hue scale: six sectors of 43 units, red at 0, green at 85, blue at 171
   localparam logic [7:0] SECTOR = 8'd43;
   localparam logic [7:0] HUE_G  = 8'd85;
   localparam logic [7:0] HUE_B  = 8'd171;

   // Serial divider geometry: 16-bit dividend, 8-bit divisor and quotient
   localparam int DIV_DW = 16;
   localparam int DIV_QW = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DIV_S,
      DIV_H,
      OUT
   } state_t;

   // Which channel holds the maximum (ties resolve R > G > B)
   typedef enum logic [1:0] {
      SEL_R,
      SEL_G,
      SEL_B
   } sel_t;

endpackage

// File: rtl/rgb2hsv_seq_div.sv
// Restoring divider 16/8 -> 8, one quotient bit per cycle, MSB first.
// Latency: start edge computes bit 7, done pulses one cycle after the 8th bit.
// Backpressure: none; a new start always restarts, the quotient holds until then.
module serial_div16by8
   import rgb2hsv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DIV_DW-1:0] dividend,
   input  logic [DIV_QW-1:0] divisor,
   output logic [DIV_QW-1:0] quotient,
   output logic              done
);

   logic [7:0] r_rem;
   logic [7:0] r_lo;
   logic [7:0] r_quo;
   logic [7:0] r_dvs;
   logic [2:0] r_cnt;
   logic       r_busy;
   logic       r_done;

   logic [7:0] w_rem_in;
   logic [7:0] w_lo_in;
   logic [7:0] w_dvs_in;
   logic [8:0] w_trial;
   logic       w_ge;
   logic [7:0] w_rem_sub;

   // On start the first step runs straight from the operands, so 8 bits need 8 edges.
   // The partial remainder is always below the divisor, so it fits 8 bits.
   assign w_rem_in  = start ? dividend[15:8] : r_rem;
   assign w_lo_in   = start ? dividend[7:0]  : r_lo;
   assign w_dvs_in  = start ? divisor        : r_dvs;
   assign w_trial   = {w_rem_in, w_lo_in[7]};
   assign w_ge      = (w_trial >= {1'b0, w_dvs_in});
   assign w_rem_sub = w_trial[7:0] - w_dvs_in;

   // One restoring step per cycle plus iteration bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rem  <= '0;
         r_lo   <= '0;
         r_quo  <= '0;
         r_dvs  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         if (start || r_busy) begin
            r_rem <= w_ge ? w_rem_sub : w_trial[7:0];
            r_lo  <= {w_lo_in[6:0], 1'b0};
            r_quo <= start ? {7'd0, w_ge} : {r_quo[6:0], w_ge};
            r_dvs <= w_dvs_in;
         end
         if (start) begin
            r_cnt  <= 3'd7;
            r_busy <= 1'b1;
            r_done <= 1'b0;
         end else if (r_busy) begin
            r_cnt  <= r_cnt - 3'd1;
            r_busy <= (r_cnt != 3'd1);
            r_done <= (r_cnt == 3'd1);
         end else begin
            r_done <= 1'b0;
         end
      end
   end

   assign quotient = r_quo;
   assign done     = r_done;

endmodule

// File: rtl/rgb2hsv_seq.sv
// Sequential RGB->HSV (hue scale 0..255, 43 per sector); RGB2HSV_DUAL_DIV_EN selects two parallel dividers.
// Latency: 18 cycles accept->out_valid (10 with RGB2HSV_DUAL_DIV_EN).
// Backpressure: single pixel in flight, in_ready only in IDLE; result holds while out_ready is low.
module rgb2hsv_seq
   import rgb2hsv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] tRGB,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [23:0] tHSV,
   output logic        out_valid,
   input  logic        out_ready
);

   state_t      r_state;
   state_t      w_state_nx;
   logic [2:0]  r_cnt;
   logic [23:0] r_pix;

   // Values settled in LOAD
   sel_t        r_sel;
   logic        r_neg;
   logic        r_zero;
   logic [7:0]  r_v;
   logic [7:0]  r_delta;
   logic [15:0] r_num;

   logic        r_out_vld;
   logic [23:0] r_hsv;

   logic [7:0]  w_r, w_g, w_b;
   sel_t        w_sel;
   logic [7:0]  w_max;
   logic [7:0]  w_min;
   logic [8:0]  w_d;
   logic [7:0]  w_abs;
   logic [15:0] w_num;
   logic [15:0] w_s_dvd;
   logic [7:0]  w_s_dvs;
   logic [7:0]  w_h_dvs;

   logic [7:0]  w_s;
   logic [7:0]  w_q_hue;
   logic        w_res_done;
   logic [7:0]  w_hue;
   logic [7:0]  w_sat;

   assign w_r = r_pix[23:16];
   assign w_g = r_pix[15:8];
   assign w_b = r_pix[7:0];

   // Max/min selection with R > G > B tie priority and the signed hue difference
   always_comb begin
      w_sel = SEL_R;
      w_max = w_r;
      w_d   = {1'b0, w_g} - {1'b0, w_b};
      if (w_r >= w_g && w_r >= w_b) begin
         w_sel = SEL_R;
         w_max = w_r;
         w_d   = {1'b0, w_g} - {1'b0, w_b};
      end else if (w_g >= w_b) begin
         w_sel = SEL_G;
         w_max = w_g;
         w_d   = {1'b0, w_b} - {1'b0, w_r};
      end else begin
         w_sel = SEL_B;
         w_max = w_b;
         w_d   = {1'b0, w_r} - {1'b0, w_g};
      end
      w_min = (w_r <= w_g) ? ((w_r <= w_b) ? w_r : w_b) : ((w_g <= w_b) ? w_g : w_b);
   end

   // |d| <= 255, so the magnitude is exact in 8 bits even for d = -255
   assign w_abs = w_d[8] ? (8'd0 - w_d[7:0]) : w_d[7:0];
   assign w_num = {8'd0, w_abs} * {8'd0, SECTOR};

   // 255*delta as a shift-subtract; divisors forced to 1 for gray so timing is unchanged
   assign w_s_dvd = {r_delta, 8'h00} - {8'h00, r_delta};
   assign w_s_dvs = r_zero ? 8'd1 : r_v;
   assign w_h_dvs = r_zero ? 8'd1 : r_delta;

`ifdef RGB2HSV_DUAL_DIV_EN
   logic [7:0] w_quo_s, w_quo_h;
   logic       w_done_s, w_done_h;
   logic       w_start;

   assign w_start = (r_state == DIV_S) && (r_cnt == 3'd0);

   serial_div16by8 u_div_s (
      .clk      (clk),
      .reset    (reset),
      .start    (w_start),
      .dividend (w_s_dvd),
      .divisor  (w_s_dvs),
      .quotient (w_quo_s),
      .done     (w_done_s)
   );

   serial_div16by8 u_div_h (
      .clk      (clk),
      .reset    (reset),
      .start    (w_start),
      .dividend (r_num),
      .divisor  (w_h_dvs),
      .quotient (w_quo_h),
      .done     (w_done_h)
   );

   assign w_s        = w_quo_s;
   assign w_q_hue    = w_quo_h;
   assign w_res_done = (r_state == OUT) && w_done_s && w_done_h;
`else
   logic [7:0] w_quo;
   logic       w_done;
   logic       w_start;
   logic [7:0] r_s;

   // Saturation first, then hue, through one shared divider
   assign w_start = ((r_state == DIV_S) || (r_state == DIV_H)) && (r_cnt == 3'd0);

   serial_div16by8 u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (w_start),
      .dividend ((r_state == DIV_H) ? r_num : w_s_dvd),
      .divisor  ((r_state == DIV_H) ? w_h_dvs : w_s_dvs),
      .quotient (w_quo),
      .done     (w_done)
   );

   // Saturation quotient is ready in the first DIV_H cycle, before the hue start overwrites it
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s <= '0;
      end else if ((r_state == DIV_H) && w_done) begin
         r_s <= w_quo;
      end
   end

   assign w_s        = r_s;
   assign w_q_hue    = w_quo;
   assign w_res_done = (r_state == OUT) && w_done;
`endif

   // FSM next state; divide phases are fixed 8-cycle windows
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nx = LOAD;
         LOAD:    w_state_nx = DIV_S;
`ifdef RGB2HSV_DUAL_DIV_EN
         DIV_S:   if (r_cnt == 3'd7) w_state_nx = OUT;
`else
         DIV_S:   if (r_cnt == 3'd7) w_state_nx = DIV_H;
`endif
         DIV_H:   if (r_cnt == 3'd7) w_state_nx = OUT;
         OUT:     if (r_out_vld && out_ready) w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // State register and per-state cycle counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= (w_state_nx != r_state) ? 3'd0 : r_cnt + 3'd1;
      end
   end

   // Pixel capture at accept, then LOAD-stage operand registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pix   <= '0;
         r_sel   <= SEL_R;
         r_neg   <= 1'b0;
         r_zero  <= 1'b0;
         r_v     <= '0;
         r_delta <= '0;
         r_num   <= '0;
      end else begin
         if (r_state == IDLE && in_valid) begin
            r_pix <= tRGB;
         end
         if (r_state == LOAD) begin
            r_sel   <= w_sel;
            r_neg   <= w_d[8];
            r_zero  <= (w_max == w_min);
            r_v     <= w_max;
            r_delta <= w_max - w_min;
            r_num   <= w_num;
         end
      end
   end

   // Hue assembly around the sector base; 8-bit wrap handles the red negative side
   always_comb begin
      w_hue = 8'd0;
      case (r_sel)
         SEL_R:   w_hue = r_neg ? (8'd0 - w_q_hue) : w_q_hue;
         SEL_G:   w_hue = r_neg ? (HUE_G - w_q_hue) : (HUE_G + w_q_hue);
         SEL_B:   w_hue = r_neg ? (HUE_B - w_q_hue) : (HUE_B + w_q_hue);
         default: w_hue = 8'd0;
      endcase
      if (r_zero) begin
         w_hue = 8'd0;
      end
      w_sat = r_zero ? 8'd0 : w_s;
   end

   // Registered result; held until the downstream handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_vld <= 1'b0;
         r_hsv     <= '0;
      end else if (w_res_done) begin
         r_out_vld <= 1'b1;
         r_hsv     <= {w_hue, w_sat, r_v};
      end else if (r_out_vld && out_ready) begin
         r_out_vld <= 1'b0;
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_vld;
   assign tHSV      = r_hsv;

endmodule

// File: tb/tb_rgb2hsv_seq.sv
// Self-checking bench for rgb2hsv_seq: directed pixels through a scoreboard queue.
// Latency: checks 18 cycles (10 with RGB2HSV_DUAL_DIV_EN) from accept to out_valid.
// Backpressure: exercises an out_ready stall and a mid-divide reset abort.
module tb_rgb2hsv_seq;

`ifdef RGB2HSV_DUAL_DIV_EN
   localparam int LAT = 10;
`else
   localparam int LAT = 18;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] tRGB;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] tHSV;
   logic        out_valid;
   logic        out_ready;

   int          vecs = 0;
   int          miscompares = 0;
   logic [23:0] exp_q[$];

   rgb2hsv_seq dut (
      .clk       (clk),
      .reset     (reset),
      .tRGB      (tRGB),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tHSV      (tHSV),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called on a negedge; returns on the negedge after the accept edge
   task automatic send(input logic [23:0] px, input logic [23:0] exp, input bit track);
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      tRGB     = px;
      in_valid = 1'b1;
      if (track) exp_q.push_back(exp);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Waits (bounded) for out_valid, checks latency and the scoreboard head
   task automatic expect_out(input string tag);
      int n = 0;
      logic [23:0] e;
      while (out_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n, LAT);
      if (exp_q.size() == 0) begin
         vecs++;
         miscompares++;
         $error("FAIL %s_scoreboard: observed output 0x%0h expected none", tag, tHSV);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {8'd0, tHSV}, {8'd0, e});
      end
   endtask

   logic [23:0] px_tab  [7] = '{24'hFF0000, 24'h00FF00, 24'h64C832, 24'hFF0080,
                                24'h808080, 24'h000000, 24'hFFFF00};
   logic [23:0] exp_tab [7] = '{24'h00FFFF, 24'h55FFFF, 24'h47BFC8, 24'hEBFFFF,
                                24'h000080, 24'h000000, 24'h2BFFFF};

   initial begin
      int seen;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tRGB      = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_tHSV", {8'd0, tHSV}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed pixels, consumed immediately
      for (int i = 0; i < 7; i++) begin
         send(px_tab[i], exp_tab[i], 1'b1);
         expect_out($sformatf("px%0d", i));
         @(negedge clk);
         chk($sformatf("px%0d_hs_out_valid", i), {31'd0, out_valid}, 32'd0);
         chk($sformatf("px%0d_hs_in_ready", i), {31'd0, in_ready}, 32'd1);
      end

      // Downstream stall for 30 cycles with a stray in_valid pulse
      out_ready = 1'b0;
      send(24'h0A141E, 24'h96AA1E, 1'b1);
      expect_out("stall_px");
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 10) begin
            tRGB     = 24'hFF0000;
            in_valid = 1'b1;
         end
         if (i == 11) in_valid = 1'b0;
         chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_tHSV", {8'd0, tHSV}, {8'd0, 24'h96AA1E});
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_out_valid", {31'd0, out_valid}, 32'd0);
      chk("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("stall_single_hs_out_valid", {31'd0, out_valid}, 32'd0);

      // Reset during the fifth DIV_S cycle discards the pixel
      send(24'hC80A0A, 24'h000000, 1'b0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_tHSV", {8'd0, tHSV}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      chk("abort_no_output", seen, 0);

      send(24'h0000FF, 24'hABFFFF, 1'b1);
      expect_out("after_abort_blue");
      @(negedge clk);
      chk("after_abort_hs_in_ready", {31'd0, in_ready}, 32'd1);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
